// File: rtl/alu_operand_fetch_if.sv
// Interface bundling the operand-fetch stage's buses.
//   in_*  : issue request (valid/ready) carrying rs1, rs2/imm and the ALU select
//   wb_*  : write-back port returning ALU results into the register file
//   out_* : operand set (valid/ready) presented to the ALU
// Modports:
//   master : the side that issues ops, writes back and consumes operands
//   slave  : the operand-fetch stage itself
interface alu_operand_fetch_if #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 3,
    parameter int unsigned SEL_W      = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [REG_ADDR_W-1:0] in_rs1;
    logic [REG_ADDR_W-1:0] in_rs2;
    logic [DATA_W-1:0]     in_imm;
    logic                  in_use_imm;
    logic [SEL_W-1:0]      in_sel;

    logic                  wb_en;
    logic [REG_ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0]     wb_data;

    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_W-1:0]     out_a;
    logic [DATA_W-1:0]     out_b;
    logic [SEL_W-1:0]      out_sel;

    modport master (
        output in_valid, in_rs1, in_rs2, in_imm, in_use_imm, in_sel,
        output wb_en, wb_addr, wb_data,
        output out_ready,
        input  in_ready, out_valid, out_a, out_b, out_sel
    );

    modport slave (
        input  in_valid, in_rs1, in_rs2, in_imm, in_use_imm, in_sel,
        input  wb_en, wb_addr, wb_data,
        input  out_ready,
        output in_ready, out_valid, out_a, out_b, out_sel
    );
endinterface

// File: rtl/alu_operand_fetch.sv
// Operand-fetch stage ahead of the 32-bit ALU: 8-entry register file (r0 reads as zero) and a
// single output pipeline register holding A, B and ALU_Sel.
// Ports:
//   clk       : rising-edge clock
//   rst       : asynchronous reset, active-high
//   bus       : alu_operand_fetch_if.slave (issue, write-back and ALU-side handshakes)
//   issue_cnt : count of accepted issues, wraps modulo 2**CNT_W
// Build option:
//   ALU_WB_BYPASS_EN : when defined, a same-cycle write-back to a register being read is
//                      forwarded into the operand; otherwise the pre-write value is used.
module alu_operand_fetch #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 3,
    parameter int unsigned SEL_W      = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_operand_fetch_if.slave   bus,
    output logic [CNT_W-1:0]     issue_cnt
);
    localparam int unsigned NREG = 2 ** REG_ADDR_W;

    logic [DATA_W-1:0] rf_q [NREG];

    logic              out_valid_q;
    logic [DATA_W-1:0] out_a_q;
    logic [DATA_W-1:0] out_b_q;
    logic [SEL_W-1:0]  out_sel_q;
    logic [CNT_W-1:0]  issue_cnt_q;

    logic              accept;
    logic              wb_write;
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;
    logic [DATA_W-1:0] operand_b;

    assign wb_write     = bus.wb_en && (bus.wb_addr != '0);
    assign bus.in_ready = !out_valid_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        rd_a = (bus.in_rs1 == '0) ? '0 : rf_q[bus.in_rs1];
        rd_b = (bus.in_rs2 == '0) ? '0 : rf_q[bus.in_rs2];
`ifdef ALU_WB_BYPASS_EN
        if (wb_write && (bus.wb_addr == bus.in_rs1)) begin
            rd_a = bus.wb_data;
        end
        if (wb_write && (bus.wb_addr == bus.in_rs2)) begin
            rd_b = bus.wb_data;
        end
`endif
        operand_b = bus.in_use_imm ? bus.in_imm : rd_b;
    end

    // Write-back is never stalled by the handshake. Entry 0 is never written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else if (wb_write) begin
            rf_q[bus.wb_addr] <= bus.wb_data;
        end
    end

    // Data outputs hold their last value after a drain; only valid drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_a_q     <= '0;
            out_b_q     <= '0;
            out_sel_q   <= '0;
            issue_cnt_q <= '0;
        end else begin
            if (accept) begin
                out_valid_q <= 1'b1;
                out_a_q     <= rd_a;
                out_b_q     <= operand_b;
                out_sel_q   <= bus.in_sel;
                issue_cnt_q <= issue_cnt_q + CNT_W'(1);
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_a     = out_a_q;
    assign bus.out_b     = out_b_q;
    assign bus.out_sel   = out_sel_q;
    assign issue_cnt     = issue_cnt_q;
endmodule

// File: tb/tb_alu_operand_fetch.sv
module tb_alu_operand_fetch;
    logic        clk;
    logic        rst;
    logic [15:0] issue_cnt;

    alu_operand_fetch_if #(.DATA_W(32), .REG_ADDR_W(3), .SEL_W(4)) bus ();

    alu_operand_fetch #(
        .DATA_W     (32),
        .REG_ADDR_W (3),
        .SEL_W      (4),
        .CNT_W      (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .issue_cnt (issue_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a queue of issued operand sets; the head is what the ALU sees.
    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  sel;
    } op_t;

    op_t         m_q[$];
    op_t         m_hold = '{a: 32'h0, b: 32'h0, sel: 4'h0};
    logic [31:0] m_rf[8];
    int          m_cnt = 0;

    initial for (int i = 0; i < 8; i++) m_rf[i] = 32'h0;

    always @(posedge clk or posedge rst) begin
        op_t nw;
        bit  empty;
        bit  acc;
        if (rst) begin
            m_q.delete();
            m_hold = '{a: 32'h0, b: 32'h0, sel: 4'h0};
            m_cnt  = 0;
            for (int i = 0; i < 8; i++) m_rf[i] = 32'h0;
        end else begin
            empty  = (m_q.size() == 0);
            acc    = bus.in_valid && (empty || bus.out_ready);
            nw.a   = (bus.in_rs1 == 0) ? 32'h0 : m_rf[bus.in_rs1];
            nw.b   = (bus.in_rs2 == 0) ? 32'h0 : m_rf[bus.in_rs2];
`ifdef ALU_WB_BYPASS_EN
            if (bus.wb_en && bus.wb_addr != 0 && bus.wb_addr == bus.in_rs1) nw.a = bus.wb_data;
            if (bus.wb_en && bus.wb_addr != 0 && bus.wb_addr == bus.in_rs2) nw.b = bus.wb_data;
`endif
            if (bus.in_use_imm) nw.b = bus.in_imm;
            nw.sel = bus.in_sel;
            if (!empty && bus.out_ready) m_hold = m_q.pop_front();
            if (acc) begin
                m_q.push_back(nw);
                m_cnt = (m_cnt + 1) % 65536;
            end
            if (bus.wb_en && bus.wb_addr != 0) m_rf[bus.wb_addr] = bus.wb_data;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        op_t pres;
        if (!rst) begin
            pres = (m_q.size() != 0) ? m_q[0] : m_hold;
            check("model.in_ready", {31'h0, bus.in_ready}, {31'h0, (m_q.size() == 0) || bus.out_ready});
            check("model.out_valid", {31'h0, bus.out_valid}, {31'h0, m_q.size() != 0});
            check("model.out_a", bus.out_a, pres.a);
            check("model.out_b", bus.out_b, pres.b);
            check("model.out_sel", {28'h0, bus.out_sel}, {28'h0, pres.sel});
            check("model.issue_cnt", {16'h0, issue_cnt}, m_cnt[31:0]);
        end
    end

    // Step to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_valid   = 1'b0;
        bus.in_rs1     = 3'd0;
        bus.in_rs2     = 3'd0;
        bus.in_imm     = 32'h0;
        bus.in_use_imm = 1'b0;
        bus.in_sel     = 4'h0;
        bus.wb_en      = 1'b0;
        bus.wb_addr    = 3'd0;
        bus.wb_data    = 32'h0;
    endtask

    task automatic issue(input logic [2:0] rs1, input logic [2:0] rs2, input logic use_imm,
                         input logic [31:0] imm, input logic [3:0] sel);
        bus.in_valid   = 1'b1;
        bus.in_rs1     = rs1;
        bus.in_rs2     = rs2;
        bus.in_use_imm = use_imm;
        bus.in_imm     = imm;
        bus.in_sel     = sel;
    endtask

    task automatic wb(input logic [2:0] addr, input logic [31:0] data);
        bus.wb_en   = 1'b1;
        bus.wb_addr = addr;
        bus.wb_data = data;
    endtask

    logic [31:0] exp_bypass_a;

    initial begin
        rst           = 1'b1;
        bus.out_ready = 1'b1;
        idle_inputs();
        repeat (2) tick();
        rst = 1'b0;
        tick();
        #1;

        // Reset then idle
        check("rst.out_valid", {31'h0, bus.out_valid}, 32'h0);
        check("rst.out_a", bus.out_a, 32'h0);
        check("rst.out_b", bus.out_b, 32'h0);
        check("rst.out_sel", {28'h0, bus.out_sel}, 32'h0);
        check("rst.issue_cnt", {16'h0, issue_cnt}, 32'h0);
        check("rst.in_ready", {31'h0, bus.in_ready}, 32'h1);

        // Register operands
        wb(3'd1, 32'h0000_000A);
        tick();
        wb(3'd2, 32'h0000_0002);
        tick();
        bus.wb_en = 1'b0;
        issue(3'd1, 3'd2, 1'b0, 32'h0, 4'h0);
        tick();
        bus.in_valid = 1'b0;
        #1;
        check("rr.out_valid", {31'h0, bus.out_valid}, 32'h1);
        check("rr.out_a", bus.out_a, 32'h0000_000A);
        check("rr.out_b", bus.out_b, 32'h0000_0002);
        check("rr.out_sel", {28'h0, bus.out_sel}, 32'h0);
        tick();

        // Immediate operand with a 3-cycle stall
        bus.out_ready = 1'b0;
        issue(3'd1, 3'd0, 1'b1, 32'h0000_000A, 4'h3);
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall.out_valid", {31'h0, bus.out_valid}, 32'h1);
            check("stall.out_a", bus.out_a, 32'h0000_000A);
            check("stall.out_b", bus.out_b, 32'h0000_000A);
            check("stall.in_ready", {31'h0, bus.in_ready}, 32'h0);
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        #1;
        check("drain.out_valid", {31'h0, bus.out_valid}, 32'h0);
        check("drain.out_b_hold", bus.out_b, 32'h0000_000A);
        check("drain.issue_cnt", {16'h0, issue_cnt}, 32'd2);

        // Same-cycle write-back and read of r1
`ifdef ALU_WB_BYPASS_EN
        exp_bypass_a = 32'h0000_00F6;
`else
        exp_bypass_a = 32'h0000_000A;
`endif
        wb(3'd1, 32'h0000_00F6);
        issue(3'd1, 3'd0, 1'b0, 32'h0, 4'h2);
        tick();
        bus.wb_en = 1'b0;
        issue(3'd1, 3'd1, 1'b0, 32'h0, 4'h6);
        #1;
        check("byp.out_a", bus.out_a, exp_bypass_a);
        check("byp.out_b_r0", bus.out_b, 32'h0);
        tick();
        bus.in_valid = 1'b0;
        #1;
        check("byp.after_a", bus.out_a, 32'h0000_00F6);
        check("byp.after_b", bus.out_b, 32'h0000_00F6);
        check("byp.issue_cnt", {16'h0, issue_cnt}, 32'd4);
        tick();

        // Write to r0 is dropped
        wb(3'd0, 32'hFFFF_FFFF);
        tick();
        bus.wb_en = 1'b0;
        issue(3'd0, 3'd0, 1'b0, 32'h0, 4'h7);
        tick();
        bus.in_valid = 1'b0;
        #1;
        check("r0.out_a", bus.out_a, 32'h0);
        check("r0.out_b", bus.out_b, 32'h0);
        check("r0.out_sel", {28'h0, bus.out_sel}, 32'h7);
        tick();

        // Back-to-back issue from a fresh reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 16; i++) begin
            issue(3'd0, 3'd0, 1'b1, 32'(i), 4'((i + 1) % 16));
            tick();
            #1;
            check("b2b.out_valid", {31'h0, bus.out_valid}, 32'h1);
            check("b2b.out_sel", {28'h0, bus.out_sel}, 32'((i + 1) % 16));
            check("b2b.out_b", bus.out_b, 32'(i));
        end
        bus.in_valid = 1'b0;
        check("b2b.issue_cnt", {16'h0, issue_cnt}, 32'd16);

        // Asynchronous reset while operands are valid
        #1;
        rst = 1'b1;
        #1;
        check("arst.out_valid", {31'h0, bus.out_valid}, 32'h0);
        check("arst.issue_cnt", {16'h0, issue_cnt}, 32'h0);
        check("arst.out_sel", {28'h0, bus.out_sel}, 32'h0);
        tick();
        rst = 1'b0;
        #1;
        check("arst.in_ready", {31'h0, bus.in_ready}, 32'h1);
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
